// File: rtl/edge_rate_meter.sv
// Purpose : counts rising edges of din over a fixed window of WINDOW cycles, started by en.
// Latency : en sampled in IDLE at cycle T -> COUNT T+1..T+WINDOW -> res_valid at T+WINDOW+1.
// Backpres: result is held stable in HOLD until res_valid & res_ready; no edges counted meanwhile.
//
// Ports:
//   clk, rst        : single clock, synchronous active-high reset
//   din             : monitored level (edge detected against its registered copy)
//   en              : start-measurement request (ignored while counting)
//   res_valid/ready : result handshake; res_count / res_ovf carry the window result
//   busy            : high while the window is being counted
//
// Configuration macro: EDGE_RATE_METER_SAT_EN
//   defined   -> accumulator saturates at all-ones on overflow
//   undefined -> accumulator wraps to zero on overflow
// In both builds res_ovf is set on overflow and stays set until the next window starts.
module edge_rate_meter #(
   parameter int WIDTH  = 8,
   parameter int WINDOW = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             en,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_count,
   output logic             res_ovf,
   output logic             busy
);

   localparam int CW = $clog2(WINDOW);
   localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             din_q, din_d;
   logic [CW-1:0]    win_q, win_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic             rise;

   assign rise = din & ~din_q;

   always_comb begin
      state_d = state_q;
      din_d   = din;
      win_d   = win_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (en) begin
               state_d = COUNT;
               win_d   = '0;
               acc_d   = '0;
               ovf_d   = 1'b0;
            end
         end

         COUNT: begin
            win_d = win_q + CW'(1);
            if (rise) begin
               if (&acc_q) begin
                  ovf_d = 1'b1;
`ifdef EDGE_RATE_METER_SAT_EN
                  acc_d = acc_q;
`else
                  acc_d = '0;
`endif
               end else begin
                  acc_d = acc_q + WIDTH'(1);
               end
            end
            // The edge seen on the last window cycle is folded in above before leaving.
            if (win_q == WIN_LAST) begin
               state_d = HOLD;
            end
         end

         HOLD: begin
            if (res_ready) begin
               if (en) begin
                  // Back-to-back: restart immediately with cleared counters.
                  state_d = COUNT;
                  win_d   = '0;
                  acc_d   = '0;
                  ovf_d   = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         din_q   <= 1'b0;
         win_q   <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         din_q   <= din_d;
         win_q   <= win_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end

   // Accumulator doubles as the result register: it is frozen outside COUNT.
   assign res_count = acc_q;
   assign res_ovf   = ovf_q;
   assign res_valid = (state_q == HOLD);
   assign busy      = (state_q == COUNT);

endmodule

// File: tb/tb_edge_rate_meter.sv
// Purpose : self-checking bench for edge_rate_meter (8-bit and 2-bit result instances).
// Latency : expected results queued when a window is driven, compared when res_valid appears.
// Backpres: bench drives res_ready explicitly per scenario.
module tb_edge_rate_meter;

   logic       clk = 1'b0;
   logic       rst, din, en, res_ready;
   logic       v8, o8, b8, v2, o2, b2;
   logic [7:0] c8;
   logic [1:0] c2;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] c8;
      logic       o8;
      logic [1:0] c2;
      logic       o2;
   } exp_t;

   exp_t sb[$];
   exp_t last;

   always #5 clk = ~clk;

   edge_rate_meter #(.WIDTH(8), .WINDOW(16)) dut8 (
      .clk(clk), .rst(rst), .din(din), .en(en),
      .res_valid(v8), .res_ready(res_ready), .res_count(c8), .res_ovf(o8), .busy(b8)
   );

   edge_rate_meter #(.WIDTH(2), .WINDOW(16)) dut2 (
      .clk(clk), .rst(rst), .din(din), .en(en),
      .res_valid(v2), .res_ready(res_ready), .res_count(c2), .res_ovf(o2), .busy(b2)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Drives one window: cycle k=0 is the start cycle (en sampled), k=1..16 are COUNT cycles.
   // mode 0: toggle starting at 0, 1: held high, 2: random, 3: held low.
   task automatic drive_window(input int mode, input bit en_hold, input bit rdy);
      bit   pat[17];
      int   n;
      exp_t e;
      n = 0;
      for (int k = 0; k < 17; k++) begin
         case (mode)
            0:       pat[k] = (k % 2) != 0;
            1:       pat[k] = 1'b1;
            2:       pat[k] = 1'($urandom_range(0, 1));
            default: pat[k] = 1'b0;
         endcase
      end
      for (int k = 1; k < 17; k++) begin
         if (pat[k] && !pat[k-1]) n++;
      end
      e.c8 = n[7:0];
      e.o8 = (n > 255);
`ifdef EDGE_RATE_METER_SAT_EN
      e.c2 = (n > 3) ? 2'd3 : n[1:0];
`else
      e.c2 = n[1:0];
`endif
      e.o2 = (n > 3);
      sb.push_back(e);
      for (int k = 0; k < 17; k++) begin
         din       = pat[k];
         en        = (k == 0) ? 1'b1 : en_hold;
         res_ready = rdy;
         step();
         if (k < 16) begin
            checks++;
            if (b8 !== 1'b1 || v8 !== 1'b0 || b2 !== 1'b1 || v2 !== 1'b0) begin
               failures++;
               $display("FAIL window_busy cycle=%0d busy8=%b valid8=%b busy2=%b valid2=%b required busy=1 valid=0",
                        k + 1, b8, v8, b2, v2);
            end
         end
      end
   endtask

   task automatic check_result;
      int   w;
      exp_t e;
      w = 0;
      while (v8 !== 1'b1 && w < 20) begin
         step();
         w++;
      end
      checks++;
      if (v8 !== 1'b1 || v2 !== 1'b1 || b8 !== 1'b0) begin
         failures++;
         $display("FAIL result_valid valid8=%b valid2=%b busy8=%b required valid=1 busy=0", v8, v2, b8);
      end
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty size=0 required >0");
      end else begin
         e    = sb.pop_front();
         last = e;
         checks++;
         if (c8 !== e.c8) begin
            failures++;
            $display("FAIL count8 got=%0d required=%0d", c8, e.c8);
         end
         checks++;
         if (o8 !== e.o8) begin
            failures++;
            $display("FAIL ovf8 got=%b required=%b", o8, e.o8);
         end
         checks++;
         if (c2 !== e.c2) begin
            failures++;
            $display("FAIL count2 got=%0d required=%0d", c2, e.c2);
         end
         checks++;
         if (o2 !== e.o2) begin
            failures++;
            $display("FAIL ovf2 got=%b required=%b", o2, e.o2);
         end
      end
   endtask

   task automatic release_to_idle;
      en        = 1'b0;
      res_ready = 1'b1;
      step();
      checks++;
      if (v8 !== 1'b0 || b8 !== 1'b0 || v2 !== 1'b0 || b2 !== 1'b0) begin
         failures++;
         $display("FAIL release_idle valid8=%b busy8=%b valid2=%b busy2=%b required all 0", v8, b8, v2, b2);
      end
      // res_ready while idle must not move the FSM.
      step();
      checks++;
      if (v8 !== 1'b0 || b8 !== 1'b0) begin
         failures++;
         $display("FAIL ready_in_idle valid8=%b busy8=%b required 0 0", v8, b8);
      end
      res_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; din = 1'b1; en = 1'b1; res_ready = 1'b0;
      step();
      step();
      checks++;
      if (v8 !== 1'b0 || c8 !== 8'd0 || o8 !== 1'b0 || b8 !== 1'b0 ||
          v2 !== 1'b0 || c2 !== 2'd0 || o2 !== 1'b0 || b2 !== 1'b0) begin
         failures++;
         $display("FAIL reset v8=%b c8=%0d o8=%b b8=%b v2=%b c2=%0d o2=%b b2=%b required all 0",
                  v8, c8, o8, b8, v2, c2, o2, b2);
      end
      en  = 1'b0;
      din = 1'b0;
      rst = 1'b0;
      step();
      checks++;
      if (b8 !== 1'b0 || v8 !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_idle busy=%b valid=%b required 0 0", b8, v8);
      end
   endtask

   task automatic test_basic;
      drive_window(0, 1'b0, 1'b0);
      check_result();
   endtask

   task automatic test_backpressure;
      for (int i = 0; i < 5; i++) begin
         din       = (i % 2) == 0;
         en        = 1'b0;
         res_ready = 1'b0;
         step();
         checks++;
         if (v8 !== 1'b1 || b8 !== 1'b0 || c8 !== last.c8 || o8 !== last.o8 || c2 !== last.c2 || o2 !== last.o2) begin
            failures++;
            $display("FAIL hold_stable cycle=%0d valid=%b busy=%b c8=%0d c2=%0d required valid=1 busy=0 c8=%0d c2=%0d",
                     i, v8, b8, c8, c2, last.c8, last.c2);
         end
      end
      release_to_idle();
   endtask

   task automatic test_back_to_back;
      drive_window(2, 1'b1, 1'b1);
      check_result();
      drive_window(1, 1'b1, 1'b1);
      check_result();
      release_to_idle();
   endtask

   task automatic test_overflow;
      drive_window(0, 1'b0, 1'b0);
      check_result();
      release_to_idle();
      // A quiet window must start with overflow cleared.
      drive_window(3, 1'b0, 1'b0);
      check_result();
      release_to_idle();
   endtask

   task automatic test_mid_reset;
      bit seen;
      din = 1'b0;
      en  = 1'b1;
      step();
      en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         din = ~din;
         step();
      end
      checks++;
      if (b8 !== 1'b1) begin
         failures++;
         $display("FAIL mid_window_busy busy=%b required 1", b8);
      end
      rst = 1'b1;
      din = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (b8 !== 1'b0 || v8 !== 1'b0 || c8 !== 8'd0 || o8 !== 1'b0 || b2 !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset busy=%b valid=%b count=%0d ovf=%b required 0 0 0 0", b8, v8, c8, o8);
      end
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         din = ~din;
         step();
         if (v8 === 1'b1 || b8 === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL no_result_after_reset seen=1 required 0");
      end
      drive_window(2, 1'b0, 1'b0);
      check_result();
      release_to_idle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_overflow();
      test_mid_reset();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover size=%0d required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
